poly_horner_eval: RTL and testbench



---
 rtl/poly_horner_eval.sv | 148 ++++++++++++++
 tb/tb_poly_horner_eval.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_horner_eval.sv
// poly_horner_eval: evaluates y = c_N*x^N + ... + c_1*x + c_0 with Horner's rule,
// one multiply-add per clock, sequenced by a small IDLE/CALC/DONE controller.
// Build option: define SATURATE_EN to clamp each step at 2^WIDTH-1 and raise ovf;
// without it every step wraps modulo 2^WIDTH and ovf is tied low.
module poly_horner_eval #(
   parameter int WIDTH  = 16,
   parameter int DEGREE = 2
) (
   input  logic                        clk,
   input  logic                        RSTN,
   input  logic                        start,
   input  logic [WIDTH-1:0]            x,
   input  logic [(DEGREE+1)*WIDTH-1:0] coef,
   output logic                        busy,
   output logic                        Pronto,
   output logic [WIDTH-1:0]            y,
   output logic                        ovf
);

   // Counter only has to index coefficients 0..DEGREE
   localparam int CNT_W = $clog2(DEGREE + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DEGREE - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] hAcc;
   logic [WIDTH-1:0] xReg;
   logic [WIDTH-1:0] coefArr [0:DEGREE];
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] stepRes;
   logic             accept;

   assign accept = (state == IDLE) && start;
   assign addend = coefArr[cnt];

`ifdef SATURATE_EN
   logic [2*WIDTH-1:0] stepFull;
   logic               stepOvf;

   // Full-precision h*x + c; the sum never exceeds 2*WIDTH bits
   function automatic logic [2*WIDTH-1:0] macFull(input logic [WIDTH-1:0] h,
                                                   input logic [WIDTH-1:0] xv,
                                                   input logic [WIDTH-1:0] c);
      logic [2*WIDTH-1:0] p;
      p = {{WIDTH{1'b0}}, h} * {{WIDTH{1'b0}}, xv};
      return p + {{WIDTH{1'b0}}, c};
   endfunction

   // Clamp a full-precision step result to the largest WIDTH-bit value
   function automatic logic [WIDTH-1:0] satReduce(input logic [2*WIDTH-1:0] full);
      if (|full[2*WIDTH-1:WIDTH])
         return {WIDTH{1'b1}};
      else
         return full[WIDTH-1:0];
   endfunction

   // One Horner step with saturation and overflow detection
   always_comb begin
      stepFull = macFull(hAcc, xReg, addend);
      stepOvf  = |stepFull[2*WIDTH-1:WIDTH];
      stepRes  = satReduce(stepFull);
   end

   // Sticky overflow: cleared by an accepted start, set by any clamped step
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN)
         ovf <= 1'b0;
      else if (accept)
         ovf <= 1'b0;
      else if ((state == CALC) && stepOvf)
         ovf <= 1'b1;
   end
`else
   // Low WIDTH bits of h*x + c are identical to the full result modulo 2^WIDTH
   function automatic logic [WIDTH-1:0] wrapMac(input logic [WIDTH-1:0] h,
                                                 input logic [WIDTH-1:0] xv,
                                                 input logic [WIDTH-1:0] c);
      logic [WIDTH-1:0] r;
      r = h * xv + c;
      return r;
   endfunction

   // One Horner step, wrapping
   always_comb begin
      stepRes = wrapMac(hAcc, xReg, addend);
   end

   assign ovf = 1'b0;
`endif

   // Operand capture on an accepted start; later input changes are ignored
   always_ff @(posedge clk) begin
      if (accept) begin
         xReg <= x;
         for (int k = 0; k <= DEGREE; k++)
            coefArr[k] <= coef[k*WIDTH +: WIDTH];
      end
   end

   // Controller and accumulator: load c_N, iterate DEGREE times, publish, pulse Pronto
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state  <= IDLE;
         cnt    <= '0;
         hAcc   <= '0;
         y      <= '0;
         Pronto <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Pronto <= 1'b0;
               if (start) begin
                  hAcc  <= coef[DEGREE*WIDTH +: WIDTH];
                  cnt   <= CNT_INIT;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               hAcc <= stepRes;
               if (cnt == '0) begin
                  y      <= stepRes;
                  Pronto <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               Pronto <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               Pronto <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_poly_horner_eval.sv
// tb_poly_horner_eval: table-driven, hand-sequenced and randomized checks of
// poly_horner_eval at WIDTH=16/DEGREE=2 and WIDTH=8/DEGREE=3.
module tb_poly_horner_eval;

   localparam bit SAT =
`ifdef SATURATE_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk;
   logic        RSTN;

   logic        startA;
   logic [15:0] xA;
   logic [47:0] coefA;
   logic        busyA, ProntoA, ovfA;
   logic [15:0] yA;

   logic        startB;
   logic [7:0]  xB;
   logic [31:0] coefB;
   logic        busyB, ProntoB, ovfB;
   logic [7:0]  yB;

   int nCmp = 0;
   int nBad = 0;
   int prontoCntA = 0;

   poly_horner_eval #(.WIDTH(16), .DEGREE(2)) dutA (
      .clk(clk), .RSTN(RSTN), .start(startA), .x(xA), .coef(coefA),
      .busy(busyA), .Pronto(ProntoA), .y(yA), .ovf(ovfA));

   poly_horner_eval #(.WIDTH(8), .DEGREE(3)) dutB (
      .clk(clk), .RSTN(RSTN), .start(startB), .x(xB), .coef(coefB),
      .busy(busyB), .Pronto(ProntoB), .y(yB), .ovf(ovfB));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (ProntoA === 1'b1) prontoCntA++;

   typedef struct {
      logic [15:0] x, c2, c1, c0, yExp;
      logic        ovfExp;
   } vecA_t;

   typedef struct {
      logic [7:0] x, c3, c2, c1, c0, yExp;
      logic       ovfExp;
   } vecB_t;

   vecA_t tabA [6];
   vecB_t tabB [3];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: Horner evaluation with per-step wrap or clamp, in plain integers
   function automatic void model(input int width, input int degree,
                                 input longint unsigned xv,
                                 input longint unsigned c [0:3],
                                 output longint unsigned yv, output bit ov);
      longint unsigned h, full, maxv;
      maxv = (64'd1 << width) - 1;
      h  = c[degree];
      ov = 1'b0;
      for (int k = degree - 1; k >= 0; k--) begin
         full = h * xv + c[k];
         if (SAT) begin
            if (full > maxv) begin
               h  = maxv;
               ov = 1'b1;
            end else begin
               h = full;
            end
         end else begin
            h = full % (maxv + 1);
         end
      end
      yv = h;
   endfunction

   // Called at a negedge with the DUT idle: start, then check E0..E3
   task automatic driveCheckA(input logic [15:0] xv, c2, c1, c0, yE,
                              input logic oE, input string tag);
      xA = xv; coefA = {c2, c1, c0}; startA = 1'b1;
      @(posedge clk); #1;
      startA = 1'b0;
      xA = 16'($urandom);
      coefA = {16'($urandom), 16'($urandom), 16'($urandom)};
      chk({tag, " busy@E0"}, busyA, 1);
      chk({tag, " pronto@E0"}, ProntoA, 0);
      chk({tag, " ovf_clr@E0"}, ovfA, 0);
      @(posedge clk); #1;
      chk({tag, " pronto@E1"}, ProntoA, 0);
      @(posedge clk); #1;
      chk({tag, " pronto@E2"}, ProntoA, 1);
      chk({tag, " y"}, yA, yE);
      chk({tag, " ovf"}, ovfA, oE);
      @(posedge clk); #1;
      chk({tag, " pronto@E3"}, ProntoA, 0);
      chk({tag, " busy@E3"}, busyA, 0);
      chk({tag, " yhold"}, yA, yE);
      chk({tag, " ovfhold"}, ovfA, oE);
   endtask

   task automatic runA(input logic [15:0] xv, c2, c1, c0, yE,
                       input logic oE, input string tag);
      @(negedge clk);
      driveCheckA(xv, c2, c1, c0, yE, oE, tag);
   endtask

   task automatic runB(input logic [7:0] xv, c3, c2, c1, c0, yE,
                       input logic oE, input string tag);
      @(negedge clk);
      xB = xv; coefB = {c3, c2, c1, c0}; startB = 1'b1;
      @(posedge clk); #1;
      startB = 1'b0;
      xB = 8'($urandom);
      chk({tag, " busy@E0"}, busyB, 1);
      @(posedge clk); #1;
      chk({tag, " pronto@E1"}, ProntoB, 0);
      @(posedge clk); #1;
      chk({tag, " pronto@E2"}, ProntoB, 0);
      @(posedge clk); #1;
      chk({tag, " pronto@E3"}, ProntoB, 1);
      chk({tag, " y"}, yB, yE);
      chk({tag, " ovf"}, ovfB, oE);
      @(posedge clk); #1;
      chk({tag, " pronto@E4"}, ProntoB, 0);
      chk({tag, " busy@E4"}, busyB, 0);
   endtask

   initial begin
      longint unsigned c [0:3];
      longint unsigned yv;
      bit ov;
      int base;

      tabA[0] = '{16'd5,   16'd2,      16'd3, 16'd4,    16'd69, 1'b0};
      tabA[1] = '{16'd2,   16'hFFFF,   16'd0, 16'd0,    SAT ? 16'hFFFF : 16'hFFFC, SAT};
      tabA[2] = '{16'd0,   16'd7,      16'd8, 16'd9,    16'd9,  1'b0};
      tabA[3] = '{16'd1,   16'd1,      16'd2, 16'd3,    16'd6,  1'b0};
      tabA[4] = '{16'h100, 16'd1,      16'd0, 16'd0,    SAT ? 16'hFFFF : 16'h0000, SAT};
      tabA[5] = '{16'd3,   16'h1000,   16'd0, 16'h10,   16'h9010, 1'b0};

      tabB[0] = '{8'd2,  8'd1, 8'd1, 8'd1, 8'd1, 8'd15, 1'b0};
      tabB[1] = '{8'd16, 8'd1, 8'd1, 8'd1, 8'd1, SAT ? 8'hFF : 8'h11, SAT};
      tabB[2] = '{8'd0,  8'd9, 8'd9, 8'd9, 8'd42, 8'd42, 1'b0};

      RSTN = 1'b0; startA = 1'b0; startB = 1'b0;
      xA = '0; coefA = '0; xB = '0; coefB = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst yA", yA, 0);
      chk("rst ProntoA", ProntoA, 0);
      chk("rst busyA", busyA, 0);
      chk("rst ovfA", ovfA, 0);
      chk("rst yB", yB, 0);
      chk("rst busyB", busyB, 0);
      @(negedge clk) RSTN = 1'b1;

      for (int i = 0; i < 6; i++)
         runA(tabA[i].x, tabA[i].c2, tabA[i].c1, tabA[i].c0, tabA[i].yExp,
              tabA[i].ovfExp, $sformatf("tabA%0d", i));
      for (int i = 0; i < 3; i++)
         runB(tabB[i].x, tabB[i].c3, tabB[i].c2, tabB[i].c1, tabB[i].c0, tabB[i].yExp,
              tabB[i].ovfExp, $sformatf("tabB%0d", i));

      // Start held high; x changes after the latch edge
      @(negedge clk);
      base = prontoCntA;
      xA = 16'd5; coefA = {16'd2, 16'd3, 16'd4}; startA = 1'b1;
      @(posedge clk); #1;            // E0
      xA = 16'd7;
      @(posedge clk); #1;            // E1
      @(posedge clk); #1;            // E2
      chk("hold pronto1", ProntoA, 1);
      chk("hold y1", yA, 69);
      @(posedge clk); #1;            // E3
      chk("hold busy@E3", busyA, 0);
      @(posedge clk); #1;            // E4: second start accepted
      chk("hold busy@E4", busyA, 1);
      startA = 1'b0;
      @(posedge clk); #1;            // E5
      chk("hold pronto@E5", ProntoA, 0);
      @(posedge clk); #1;            // E6
      chk("hold pronto2", ProntoA, 1);
      chk("hold y2", yA, 123);
      repeat (3) @(posedge clk);
      #1;
      chk("hold busy end", busyA, 0);
      chk("hold pulses", prontoCntA - base, 2);

      // Asynchronous reset in the middle of an evaluation
      @(negedge clk);
      xA = 16'd5; coefA = {16'd2, 16'd3, 16'd4}; startA = 1'b1;
      @(posedge clk); #1;            // E0
      startA = 1'b0;
      @(posedge clk); #3;            // just after E1
      RSTN = 1'b0;
      #1;
      chk("abort y", yA, 0);
      chk("abort pronto", ProntoA, 0);
      chk("abort busy", busyA, 0);
      base = prontoCntA;
      repeat (2) @(negedge clk);
      RSTN = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("abort no pronto", prontoCntA - base, 0);
      chk("abort idle", busyA, 0);
      @(negedge clk);
      RSTN = 1'b0;
      @(negedge clk);
      RSTN = 1'b1;
      driveCheckA(16'd5, 16'd2, 16'd3, 16'd4, 16'd69, 1'b0, "post-reset");

      // Randomized against the reference model
      for (int i = 0; i < 20; i++) begin
         logic [15:0] rx, r2, r1, r0;
         rx = (i < 10) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         r2 = 16'($urandom); r1 = 16'($urandom); r0 = 16'($urandom);
         if (i < 5) r2 = 16'($urandom_range(0, 3));
         c[0] = r0; c[1] = r1; c[2] = r2; c[3] = 0;
         model(16, 2, rx, c, yv, ov);
         runA(rx, r2, r1, r0, 16'(yv), ov, $sformatf("rndA%0d", i));
      end
      for (int i = 0; i < 12; i++) begin
         logic [7:0] rx, r3, r2, r1, r0;
         rx = (i < 6) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         r3 = 8'($urandom_range(0, 3)); r2 = 8'($urandom);
         r1 = 8'($urandom); r0 = 8'($urandom);
         c[0] = r0; c[1] = r1; c[2] = r2; c[3] = r3;
         model(8, 3, rx, c, yv, ov);
         runB(rx, r3, r2, r1, r0, 8'(yv), ov, $sformatf("rndB%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
